perf_counter_unit: RTL

PERF_COUNTER_UNIT -- requirements
Module: perf_counter_unit

---
 rtl/perf_counter_unit_if.sv | 20 ++
 rtl/perf_counter_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/perf_counter_unit_if.sv
// CSR access port of the performance counter unit: request fields from the
// core, registered read data and access-fault flag back.
interface perf_counter_unit_if;
  logic [11:0] csr_address;
  logic        csr_read_enable;
  logic        csr_write_enable;
  logic [31:0] csr_write_data;
  logic [31:0] csr_read_data;
  logic        csr_illegal;

  modport master (
    output csr_address, csr_read_enable, csr_write_enable, csr_write_data,
    input  csr_read_data, csr_illegal
  );

  modport slave (
    input  csr_address, csr_read_enable, csr_write_enable, csr_write_data,
    output csr_read_data, csr_illegal
  );
endinterface

// File: rtl/perf_counter_unit.sv
// Performance counter unit: cycle, time, instret and hpm counters behind a
// registered CSR port, with per-counter inhibit and a prescaled time base.
module perf_counter_unit #(
  parameter int unsigned NUM_EVENTS    = 4,
  parameter int unsigned COUNTER_WIDTH = 64,
  parameter int unsigned TIME_DIVIDER  = 1
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic                                         pipe_enable,
  input  logic                                         instret_valid,
  input  logic [(NUM_EVENTS > 0 ? NUM_EVENTS : 1)-1:0] events,
  perf_counter_unit_if.slave                           csr
);

  // Counter index: 0 cycle, 1 time, 2 instret, 3+i hpm[i]; index k sits at
  // CSR offset k in both the 0xC00 and 0xB00 windows.
  localparam int         NUM_CNT  = 3 + int'(NUM_EVENTS);
  localparam int         CW       = int'(COUNTER_WIDTH);
  localparam int         HI_W     = CW - 32;
  localparam int         PRE_W    = (TIME_DIVIDER > 1) ? $clog2(TIME_DIVIDER) : 1;
  localparam logic [4:0] IDX_TIME = 5'd1;

  function automatic logic [31:0] inhibit_mask();
    logic [31:0] m;
    m = 32'h0000_0005;
    for (int i = 0; i < int'(NUM_EVENTS); i++) m[3+i] = 1'b1;
    return m;
  endfunction

  localparam logic [31:0] INH_MASK = inhibit_mask();

  logic [31:0]      cnt_lo [NUM_CNT];
  logic [HI_W-1:0]  cnt_hi [NUM_CNT];
  logic [31:0]      inhibit;
  logic [PRE_W-1:0] prescaler;
  logic             time_tick;

  logic [11:0]        addr;
  logic [4:0]         sel_idx;
  logic               sel_hi;
  logic               in_range;
  logic               user_hit;
  logic               mach_hit;
  logic               inh_hit;
  logic               any_access;
  logic               illegal_nxt;
  logic [31:0]        rd_val;
  logic [NUM_CNT-1:0] inc;
  logic [NUM_CNT-1:0] wr_sel;

  // ---------------------------------------------------------------- decode
  assign addr       = csr.csr_address;
  assign sel_idx    = addr[4:0];
  assign sel_hi     = addr[7];
  assign in_range   = (addr[6:5] == 2'b00) && (int'(sel_idx) < NUM_CNT);
  assign user_hit   = (addr[11:8] == 4'hC) && in_range;
  assign mach_hit   = (addr[11:8] == 4'hB) && in_range && (sel_idx != IDX_TIME);
  assign inh_hit    = (addr == 12'h320);
  assign any_access = csr.csr_read_enable || csr.csr_write_enable;

  // The user window is read-only, so a write there faults even when mapped.
  assign illegal_nxt = (any_access && !(user_hit || mach_hit || inh_hit)) ||
                       (csr.csr_write_enable && (addr[11:8] == 4'hC));

  assign time_tick = (prescaler == PRE_W'(TIME_DIVIDER - 1));

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rd_val = '0;
    if (inh_hit) rd_val = inhibit;
    for (int j = 0; j < NUM_CNT; j++) begin
      if ((user_hit || mach_hit) && (sel_idx == 5'(j)))
        rd_val = sel_hi ? 32'(cnt_hi[j]) : cnt_lo[j];
    end
  end

  always_comb begin
    inc    = '0;
    wr_sel = '0;
    inc[0] = !inhibit[0];
    inc[1] = time_tick;
    inc[2] = pipe_enable && instret_valid && !inhibit[2];
    for (int i = 0; i < int'(NUM_EVENTS); i++)
      inc[3+i] = events[i] && !inhibit[3+i];
    for (int j = 0; j < NUM_CNT; j++)
      wr_sel[j] = csr.csr_write_enable && mach_hit && (sel_idx == 5'(j));
  end

  // -------------------------------------------------------------- counters
  // NOTE: non-blocking assignments make every counter, and the CSR read,
  // see pre-edge values; a same-cycle read of a written counter therefore
  // returns the old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < NUM_CNT; j++) begin
        cnt_lo[j] <= '0;
        cnt_hi[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_CNT; j++) begin
        // A write replaces one half and suppresses that cycle's increment.
        if (wr_sel[j] && !sel_hi)
          cnt_lo[j] <= csr.csr_write_data;
        else if (wr_sel[j] && sel_hi)
          cnt_hi[j] <= csr.csr_write_data[HI_W-1:0];
        else if (inc[j])
          {cnt_hi[j], cnt_lo[j]} <= {cnt_hi[j], cnt_lo[j]} + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       prescaler <= '0;
    else if (time_tick) prescaler <= '0;
    else                prescaler <= prescaler + PRE_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      inhibit <= '0;
    else if (csr.csr_write_enable && inh_hit)
      inhibit <= csr.csr_write_data & INH_MASK;
  end

  // ------------------------------------------------------------ CSR output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csr.csr_read_data <= '0;
      csr.csr_illegal   <= 1'b0;
    end else begin
      if (csr.csr_read_enable) csr.csr_read_data <= rd_val;
      csr.csr_illegal <= illegal_nxt;
    end
  end

endmodule
